pc_fetch: RTL and testbench

- PC register and instruction-fetch sequencer; the consumer of the next-PC value produced by the next-PC generator.
- Holds the architectural PC and drives `pc` to the next-PC generator and the instruction-memory port.
- Issues one instruction-memory request at a time and presents the returned instruction to decode with a valid/ready handshake.
- Loads the returned `npc` only when decode accepts the current instruction.

---
 rtl/pc_fetch.sv | 119 +++++++++++
 tb/tb_pc_fetch.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// pc_fetch: architectural PC register and single-outstanding instruction
// fetch sequencer. Requests one word at a time from instruction memory,
// hands it to decode over a valid/ready handshake, and advances the PC to
// the externally computed npc only when decode accepts the instruction.
// A misaligned npc halts fetch until the next reset.
//
// RESET_PC must be 4-byte aligned.

module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      npc,
    output logic [31:0]      pc,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic             inst_valid,
    output logic [31:0]      inst,
    output logic [31:0]      inst_pc,
    input  logic             inst_ready,
    output logic             misalign_err,
    output logic [CNT_W-1:0] inst_count
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] VALID = 3'd3;
    localparam logic [2:0] HALT  = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0] state;
    logic [2:0] state_next;
    logic       grant;
    logic       capture;
    logic       accept;
    logic       npc_aligned;

    // The request address is the PC itself, so the two can never diverge.
    assign imem_addr = pc;

    // A response only counts while waiting for one; a grant only while
    // requesting. This is what drops stale or protocol-violating rvalids.
    assign grant       = (state == REQ) && imem_gnt;
    assign capture     = (state == WAIT) && imem_rvalid;
    assign accept      = (state == VALID) && inst_ready;
    assign npc_aligned = (npc[1:0] == 2'b00);

    // Next-state selection for the fetch sequencer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = REQ;
            REQ:     if (grant)   state_next = WAIT;
            WAIT:    if (capture) state_next = VALID;
            VALID:   if (accept)  state_next = npc_aligned ? REQ : HALT;
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    // State register plus the handshake outputs, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            imem_req   <= 1'b0;
            inst_valid <= 1'b0;
        end else begin
            state      <= state_next;
            imem_req   <= (state_next == REQ);
            inst_valid <= (state_next == VALID);
        end
    end

    // PC advances only on acceptance, so npc is ignored at every other time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (accept) begin
            pc <= npc;
        end
    end

    // Capture the returned word together with the address it came from.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst    <= 32'h0000_0000;
            inst_pc <= 32'h0000_0000;
        end else if (capture) begin
            inst    <= imem_rdata;
            inst_pc <= pc;
        end
    end

    // Sticky misalignment flag; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else if (accept && !npc_aligned) begin
            misalign_err <= 1'b1;
        end
    end

    // Retired-instruction counter, wrapping naturally at its width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_count <= '0;
        end else if (accept) begin
            inst_count <= inst_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed scoreboard bench for pc_fetch. Expected grant
// addresses and accepted instructions are queued by the stimulus; monitors
// pop and compare them as the DUT grants requests and hands off words.

module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] npc;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        misalign_err;
    logic [31:0] inst_count;

    logic        npc_override = 1'b0;
    logic [31:0] npc_value    = 32'h0;

    int checks = 0;
    int errors = 0;

    logic [31:0] grant_q[$];
    logic [63:0] accept_q[$];
    int          grant_seen  = 0;
    int          accept_seen = 0;

    int gnt_delay = 0;
    int rv_delay  = 0;
    int mem_phase = 0;
    int mem_cnt   = 0;
    logic [31:0] mem_addr = 32'h0;

    logic [31:0] mon_grant;
    logic [63:0] mon_accept;

    // Clock generation.
    always #5 clk = ~clk;

    // Next-PC generator stand-in: sequential unless a redirect is forced.
    assign npc = npc_override ? npc_value : pc + 32'd4;

    pc_fetch #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .npc          (npc),
        .pc           (pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .inst_ready   (inst_ready),
        .misalign_err (misalign_err),
        .inst_count   (inst_count)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0000_0013 | (a << 12);
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic ready, input logic ovr,
                                  input logic [31:0] nv);
        inst_ready   = ready;
        npc_override = ovr;
        npc_value    = nv;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_accepts(input int n, input int budget);
        int i = 0;
        while (accept_seen < n && i < budget) begin
            tick();
            i++;
        end
        if (accept_seen < n) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got %0d accepts expected %0d", accept_seen, n);
        end
    endtask

    task automatic wait_grants(input int n, input int budget);
        int i = 0;
        while (grant_seen < n && i < budget) begin
            tick();
            i++;
        end
        if (grant_seen < n) begin
            checks++;
            errors++;
            $display("[TB] FAIL grant_timeout: got %0d grants expected %0d", grant_seen, n);
        end
    endtask

    task automatic wait_valid(input int budget);
        int i = 0;
        while (!inst_valid && i < budget) begin
            tick();
            i++;
        end
        if (!inst_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL valid_timeout: got inst_valid 0 expected 1");
        end
    endtask

    // Memory model: grant after gnt_delay cycles of request, then return
    // data rv_delay cycles after the grant. Deliberately ignores rst_n so
    // that a response in flight across a DUT reset arrives stale.
    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        forever begin
            tick();
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
            if (mem_phase == 0) begin
                if (imem_req) begin
                    if (mem_cnt >= gnt_delay) begin
                        imem_gnt  = 1'b1;
                        mem_addr  = imem_addr;
                        mem_cnt   = 0;
                        mem_phase = 1;
                    end else begin
                        mem_cnt++;
                    end
                end
            end else begin
                if (mem_cnt >= rv_delay) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(mem_addr);
                    mem_cnt     = 0;
                    mem_phase   = 0;
                end else begin
                    mem_cnt++;
                end
            end
        end
    end

    // Monitor: compare each granted request and each accepted instruction
    // against the next queued expectation.
    always @(negedge clk) begin
        if (rst_n && imem_req && imem_gnt) begin
            grant_seen++;
            if (grant_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_grant: got addr %h expected none", imem_addr);
            end else begin
                mon_grant = grant_q.pop_front();
                check_output("grant_addr", imem_addr, mon_grant);
            end
        end
        if (rst_n && inst_valid && inst_ready) begin
            accept_seen++;
            if (accept_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_accept: got inst_pc %h expected none", inst_pc);
            end else begin
                mon_accept = accept_q.pop_front();
                check_output("accept_inst_pc", inst_pc, mon_accept[63:32]);
                check_output("accept_inst", inst, mon_accept[31:0]);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        int req_cycles;

        rst_n = 1'b0;
        apply_stimulus(1'b1, 1'b0, 32'h0);
        repeat (2) tick();

        // Reset state
        check_output("rst_pc", pc, 32'h0);
        check_output("rst_imem_req", {31'b0, imem_req}, 32'h0);
        check_output("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
        check_output("rst_inst", inst, 32'h0);
        check_output("rst_inst_pc", inst_pc, 32'h0);
        check_output("rst_misalign", {31'b0, misalign_err}, 32'h0);
        check_output("rst_count", inst_count, 32'h0);

        // Sequential fetch with zero-wait memory
        grant_q.push_back(32'h0);
        grant_q.push_back(32'h4);
        grant_q.push_back(32'h8);
        grant_q.push_back(32'hC);
        accept_q.push_back({32'h0, 32'h0000_0013});
        accept_q.push_back({32'h4, 32'h0000_4013});
        accept_q.push_back({32'h8, 32'h0000_8013});
        accept_q.push_back({32'hC, 32'h0000_C013});
        rst_n = 1'b1;
        wait_accepts(3, 40);
        check_output("count_after_3", inst_count, 32'd3);

        // Backpressure: hold decode off for five cycles in VALID
        apply_stimulus(1'b0, 1'b0, 32'h0);
        wait_valid(20);
        gnt_delay = 3;
        rv_delay  = 4;
        grant_q.push_back(32'h10);
        accept_q.push_back({32'h10, 32'h0001_0013});
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b0, 1'b1, 32'h40);
            check_output("stall_valid", {31'b0, inst_valid}, 32'h1);
            check_output("stall_inst", inst, 32'h0000_C013);
            check_output("stall_inst_pc", inst_pc, 32'hC);
            check_output("stall_pc", pc, 32'hC);
            check_output("stall_no_req", {31'b0, imem_req}, 32'h0);
            check_output("stall_count", inst_count, 32'd3);
            tick();
        end
        apply_stimulus(1'b1, 1'b0, 32'h0);
        wait_accepts(4, 10);
        check_output("bp_pc", pc, 32'h10);
        check_output("bp_count", inst_count, 32'd4);
        check_output("bp_valid_drop", {31'b0, inst_valid}, 32'h0);
        check_output("bp_req_next", {31'b0, imem_req}, 32'h1);

        // Slow memory: request must hold with a constant address
        apply_stimulus(1'b0, 1'b1, 32'h100);
        req_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (inst_valid) break;
            if (imem_req) begin
                req_cycles++;
                check_output("slow_addr", imem_addr, 32'h10);
            end
            tick();
        end
        check_output("slow_valid", {31'b0, inst_valid}, 32'h1);
        check_output("slow_req_cycles", req_cycles, 32'd4);

        // Redirect; an npc change while stalled must not matter
        apply_stimulus(1'b0, 1'b1, 32'h200);
        tick();
        tick();
        gnt_delay = 0;
        rv_delay  = 0;
        grant_q.push_back(32'h100);
        accept_q.push_back({32'h100, 32'h0010_0013});
        apply_stimulus(1'b1, 1'b1, 32'h100);
        wait_accepts(5, 10);
        check_output("redir_pc", pc, 32'h100);
        check_output("redir_req", {31'b0, imem_req}, 32'h1);
        check_output("redir_count", inst_count, 32'd5);

        // Misalignment halts fetch
        apply_stimulus(1'b1, 1'b1, 32'h102);
        wait_accepts(6, 30);
        check_output("mis_err", {31'b0, misalign_err}, 32'h1);
        check_output("mis_pc", pc, 32'h102);
        check_output("mis_valid", {31'b0, inst_valid}, 32'h0);
        check_output("mis_count", inst_count, 32'd6);
        req_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req) req_cycles++;
            tick();
        end
        check_output("halt_no_req", req_cycles, 32'd0);
        check_output("halt_err_sticky", {31'b0, misalign_err}, 32'h1);
        check_output("halt_pc_hold", pc, 32'h102);

        // Reset out of HALT, then reset again mid-WAIT with a stale response
        apply_stimulus(1'b1, 1'b0, 32'h0);
        rv_delay = 3;
        rst_n = 1'b0;
        #1;
        check_output("halt_rst_pc", pc, 32'h0);
        check_output("halt_rst_err", {31'b0, misalign_err}, 32'h0);
        check_output("halt_rst_count", inst_count, 32'd0);
        grant_q.push_back(32'h0);
        grant_q.push_back(32'h0);
        accept_q.push_back({32'h0, 32'h0000_0013});
        tick();
        rst_n = 1'b1;
        wait_grants(7, 20);
        rst_n = 1'b0;
        #1;
        check_output("wait_rst_req", {31'b0, imem_req}, 32'h0);
        check_output("wait_rst_pc", pc, 32'h0);
        tick();
        rst_n = 1'b1;
        wait_accepts(7, 40);
        check_output("restart_count", inst_count, 32'd1);
        check_output("restart_pc", pc, 32'h4);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        grant_q.push_back(32'h4);
        wait_valid(40);
        check_output("final_inst_pc", inst_pc, 32'h4);
        check_output("final_inst", inst, 32'h0000_4013);
        check_output("grant_q_empty", 32'(grant_q.size()), 32'd0);
        check_output("accept_q_empty", 32'(accept_q.size()), 32'd0);

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
